pwm_fade_ctrl: RTL and testbench
================================

PWM_FADE_CTRL -- requirements
Module: pwm_fade_ctrl

Interface
REQ-001 The block SHALL have parameter PWM_BITS, default 8, meaning width of the duty value and the PWM counter; period is 2^PWM_BITS clocks.
REQ-002 The block SHALL have parameter CYCLES, default 0, meaning the number of fade cycles per start; 0 means run until stop.
REQ-003 The block SHALL have port clk, input, width 1, meaning the single system clock (48 MHz on target).
REQ-004 The block SHALL have port rst, input, width 1, meaning asynchronous active-high reset.
REQ-005 The block SHALL have port start, input, width 1, meaning a one-cycle request to begin a fade sequence.
REQ-006 The block SHALL have port stop, input, width 1, meaning a one-cycle request to end the sequence gracefully.
REQ-007 The block SHALL have port step_div, input, width 16, meaning the number of PWM periods per duty step, minus one.
REQ-008 The block SHALL have port hold_len, input, width 8, meaning the number of PWM periods spent at peak and at trough, minus one.
REQ-009 The block SHALL have port max_duty, input, width PWM_BITS, meaning the peak duty value.
REQ-010 The block SHALL have port pwm, output, width 1, meaning the PWM waveform.
REQ-011 The block SHALL have port duty, output, width PWM_BITS, meaning the current applied duty.
REQ-012 The block SHALL have port busy, output, width 1, meaning a sequence is in progress.
REQ-013 The block SHALL have port done, output, width 1, meaning a one-cycle pulse on return to IDLE.

Function
REQ-014 The block SHALL implement the states IDLE, UP, HOLD_HI, DOWN and HOLD_LO.
REQ-015 The block SHALL latch step_div, hold_len and max_duty on an accepted start; later changes to these inputs SHALL have no effect until the next start.
REQ-016 When start is high in IDLE at cycle T, the block SHALL at T+1 be in UP with busy=1, counter=0, duty=0, step count=0 and cycle count=0.
REQ-017 The block SHALL ignore start while busy=1, and SHALL ignore stop while in IDLE.
REQ-018 While busy=1, the PWM counter SHALL increment every clock and wrap from 2^PWM_BITS-1 to 0; that last count is the period boundary.
REQ-019 The block SHALL drive pwm=1 exactly when busy=1 and counter<duty, registered, with no combinational path from inputs to outputs.
REQ-020 The block SHALL make all duty and state changes only at a period boundary, taking effect when the counter reads 0.
REQ-021 Step tick: at each boundary in UP or DOWN, if step count==step_div then a tick SHALL occur and step count SHALL clear; otherwise step count SHALL increment.
REQ-022 UP: at a boundary, if duty==max_duty the block SHALL go to HOLD_HI with hold count 0; otherwise, on a tick, duty SHALL increment by 1.
REQ-023 HOLD_HI: at a boundary, if hold count==hold_len the block SHALL go to DOWN with step count 0; otherwise hold count SHALL increment.
REQ-024 DOWN: at a boundary with duty==0, the cycle count SHALL increment.
REQ-025 DOWN, at a boundary with duty==0: if stop is pending, or CYCLES!=0 and the new cycle count==CYCLES, the block SHALL go to IDLE; otherwise it SHALL go to HOLD_LO with hold count 0.
REQ-026 DOWN: at a boundary with duty!=0, on a tick, duty SHALL decrement by 1.
REQ-027 HOLD_LO: at a boundary, when hold count==hold_len the block SHALL go to UP with step count 0; otherwise hold count SHALL increment.
REQ-028 The block SHALL set a stop-pending flag on stop while busy, hold it until IDLE, and clear it on entry to IDLE.
REQ-029 On entry to IDLE the block SHALL set busy=0, duty=0 and pwm=0, and SHALL pulse done for exactly one cycle.
REQ-030 The duty arithmetic SHALL never wrap: no increment above max_duty and no decrement below 0.
REQ-031 With max_duty=0, the block SHALL spend one period in UP, then proceed through HOLD_HI and DOWN with pwm held at 0.
REQ-032 Full scale (max_duty=2^PWM_BITS-1) SHALL give pwm high 2^PWM_BITS-1 of every 2^PWM_BITS clocks; 100% duty is not required.

Reset
REQ-033 While rst=1, the block SHALL asynchronously force the state to IDLE and pwm=0, duty=0, busy=0 and done=0, and SHALL clear all counters and stop-pending.
REQ-034 Reset SHALL take priority over start when both are high in the same cycle.
REQ-035 Reset mid-sequence SHALL abort the sequence without a done pulse.

Verification (PWM_BITS=4, 16-clock period)
REQ-036 The bench SHALL cover: CYCLES=1, step_div=0, max_duty=3, hold_len=0, start -> per-period duty 0,1,2,3,3,3,2,1,0 -> done at clock 144 after busy rises, and high-time per period equals duty.
REQ-037 The bench SHALL cover: CYCLES=0, stop pulsed during the second UP -> the sequence completes DOWN to 0, skips HOLD_LO, one done pulse, busy=0.
REQ-038 The bench SHALL cover: step_div=2, max_duty=2, CYCLES=1 -> each duty value is held for 3 periods during the ramp.
REQ-039 The bench SHALL cover: max_duty=0, CYCLES=1 -> 3 periods busy, pwm never high, done once.
REQ-040 The bench SHALL cover: a second start while busy -> ignored; start with rst in the same cycle -> stays IDLE.
REQ-041 The bench SHALL cover: rst asserted mid-HOLD_HI -> outputs are 0 immediately, no done pulse, and a subsequent start restarts cleanly from duty 0.

Source files
------------

// File: rtl/pwm_fade_ctrl.sv
// Breathing-LED style PWM fader: ramps duty 0 -> max_duty -> 0 with holds at
// peak and trough, changing duty and state only at PWM period boundaries.
module pwm_fade_ctrl #(
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned CYCLES   = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic [15:0]         step_div,
  input  logic [7:0]          hold_len,
  input  logic [PWM_BITS-1:0] max_duty,
  output logic                pwm,
  output logic [PWM_BITS-1:0] duty,
  output logic                busy,
  output logic                done
);

  localparam int unsigned STEP_W = 16;
  localparam int unsigned HOLD_W = 8;
  localparam int unsigned CYC_W  = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UP,
    S_HOLD_HI,
    S_DOWN,
    S_HOLD_LO
  } state_t;

  state_t              state_q, state_d;
  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [CYC_W-1:0]    cyc_q, cyc_d;
  logic                stop_pend_q, stop_pend_d;
  logic [STEP_W-1:0]   step_div_q, step_div_d;
  logic [HOLD_W-1:0]   hold_len_q, hold_len_d;
  logic [PWM_BITS-1:0] max_duty_q, max_duty_d;
  logic                pwm_q, pwm_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                boundary_c;
  logic                tick_c;
  logic [CYC_W-1:0]    cyc_inc_c;

  // Next-state: config is frozen at start, everything else moves only at the
  // last count of a period so the new values appear when the counter reads 0.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    duty_d      = duty_q;
    step_d      = step_q;
    hold_d      = hold_q;
    cyc_d       = cyc_q;
    stop_pend_d = stop_pend_q;
    step_div_d  = step_div_q;
    hold_len_d  = hold_len_q;
    max_duty_d  = max_duty_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pwm_d       = 1'b0;

    boundary_c = (cnt_q == {PWM_BITS{1'b1}});
    tick_c     = (step_q == step_div_q);
    cyc_inc_c  = cyc_q + CYC_W'(1);

    if (state_q == S_IDLE) begin
      if (start) begin
        state_d     = S_UP;
        busy_d      = 1'b1;
        cnt_d       = '0;
        duty_d      = '0;
        step_d      = '0;
        hold_d      = '0;
        cyc_d       = '0;
        stop_pend_d = 1'b0;
        step_div_d  = step_div;
        hold_len_d  = hold_len;
        max_duty_d  = max_duty;
      end
    end else begin
      cnt_d = cnt_q + PWM_BITS'(1);
      if (stop) stop_pend_d = 1'b1;

      if (boundary_c) begin
        if (state_q == S_UP || state_q == S_DOWN) begin
          step_d = tick_c ? '0 : step_q + STEP_W'(1);
        end

        case (state_q)
          S_UP: begin
            if (duty_q == max_duty_q) begin
              state_d = S_HOLD_HI;
              hold_d  = '0;
            end else if (tick_c) begin
              duty_d = duty_q + PWM_BITS'(1);
            end
          end
          S_HOLD_HI: begin
            if (hold_q == hold_len_q) begin
              state_d = S_DOWN;
              step_d  = '0;
            end else begin
              hold_d = hold_q + HOLD_W'(1);
            end
          end
          S_DOWN: begin
            if (duty_q == '0) begin
              cyc_d = cyc_inc_c;
              if (stop_pend_q || (CYCLES != 0 && cyc_inc_c == CYC_W'(CYCLES))) begin
                state_d     = S_IDLE;
                busy_d      = 1'b0;
                duty_d      = '0;
                cnt_d       = '0;
                done_d      = 1'b1;
                stop_pend_d = 1'b0;
              end else begin
                state_d = S_HOLD_LO;
                hold_d  = '0;
              end
            end else if (tick_c) begin
              duty_d = duty_q - PWM_BITS'(1);
            end
          end
          S_HOLD_LO: begin
            if (hold_q == hold_len_q) begin
              state_d = S_UP;
              step_d  = '0;
            end else begin
              hold_d = hold_q + HOLD_W'(1);
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end

    // Compare against next-cycle counter/duty so pwm lines up with the counter.
    pwm_d = busy_d && (cnt_d < duty_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      duty_q      <= '0;
      step_q      <= '0;
      hold_q      <= '0;
      cyc_q       <= '0;
      stop_pend_q <= 1'b0;
      step_div_q  <= '0;
      hold_len_q  <= '0;
      max_duty_q  <= '0;
      pwm_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      duty_q      <= duty_d;
      step_q      <= step_d;
      hold_q      <= hold_d;
      cyc_q       <= cyc_d;
      stop_pend_q <= stop_pend_d;
      step_div_q  <= step_div_d;
      hold_len_q  <= hold_len_d;
      max_duty_q  <= max_duty_d;
      pwm_q       <= pwm_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign pwm  = pwm_q;
  assign duty = duty_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Bench for pwm_fade_ctrl at PWM_BITS=4: one instance with CYCLES=0, one with
// CYCLES=1; per-period duty/waveform checked against a period-list model.
module tb_pwm_fade_ctrl;

  localparam int unsigned PB  = 4;
  localparam int          PER = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start0 = 1'b0, start1 = 1'b0;
  logic          stop0 = 1'b0, stop1 = 1'b0;
  logic [15:0]   step_div = '0;
  logic [7:0]    hold_len = '0;
  logic [PB-1:0] max_duty = '0;
  logic          pwm0, pwm1, busy0, busy1, done0, done1;
  logic [PB-1:0] duty0, duty1;
  logic          sel = 1'b1;
  logic          pwm_s, busy_s, done_s;
  logic [PB-1:0] duty_s;

  int tests = 0;
  int fails = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  pwm_fade_ctrl #(.PWM_BITS(PB), .CYCLES(0)) u0 (
    .clk(clk), .rst(rst), .start(start0), .stop(stop0),
    .step_div(step_div), .hold_len(hold_len), .max_duty(max_duty),
    .pwm(pwm0), .duty(duty0), .busy(busy0), .done(done0)
  );

  pwm_fade_ctrl #(.PWM_BITS(PB), .CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .stop(stop1),
    .step_div(step_div), .hold_len(hold_len), .max_duty(max_duty),
    .pwm(pwm1), .duty(duty1), .busy(busy1), .done(done1)
  );

  assign pwm_s  = sel ? pwm1  : pwm0;
  assign duty_s = sel ? duty1 : duty0;
  assign busy_s = sel ? busy1 : busy0;
  assign done_s = sel ? done1 : done0;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Duty of every busy period, built from the ramp/hold rules directly.
  // stop_at: period index during which stop is pulsed (-1 = never).
  function automatic void build_model(input int sd, input int hl, input int mx,
                                      input int cycles, input int stop_at);
    int d, sc, cyc, idx;
    bit fin;
    exp_q.delete();
    d = 0; cyc = 0; fin = 0;
    while (!fin && exp_q.size() < 4000) begin
      sc = 0;
      for (int g = 0; g < 4000; g++) begin
        exp_q.push_back(d);
        if (d == mx) break;
        if (sc == sd) begin sc = 0; d++; end else sc++;
      end
      for (int h = 0; h <= hl; h++) exp_q.push_back(d);
      sc = 0;
      for (int g = 0; g < 4000; g++) begin
        idx = exp_q.size();
        exp_q.push_back(d);
        if (d == 0) begin
          cyc++;
          if ((stop_at >= 0 && idx >= stop_at) || (cycles != 0 && cyc == cycles)) fin = 1;
          break;
        end
        if (sc == sd) begin sc = 0; d--; end else sc++;
      end
      if (!fin) for (int h = 0; h <= hl; h++) exp_q.push_back(0);
    end
  endfunction

  // Start one sequence on instance sel_i and check it period by period.
  task automatic run_seq(input string tag, input int sel_i, input int sd, input int hl,
                         input int mx, input int stop_at, input int restart_at,
                         output int nper, output int hsum);
    int mis, high, e, extra;
    build_model(sd, hl, mx, sel_i, stop_at);
    @(negedge clk);
    sel      = (sel_i != 0);
    step_div = 16'(sd);
    hold_len = 8'(hl);
    max_duty = PB'(mx);
    if (sel_i != 0) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    step_div = 16'($urandom);
    hold_len = 8'($urandom);
    max_duty = PB'($urandom);
    nper = 0; hsum = 0;
    for (int k = 0; k < exp_q.size(); k++) begin
      e = exp_q[k]; mis = 0; high = 0;
      for (int j = 0; j < PER; j++) begin
        if (sel_i != 0) begin
          stop1  = (k == stop_at && j == 3);
          start1 = (k == restart_at && j == 5);
        end else begin
          stop0  = (k == stop_at && j == 3);
          start0 = (k == restart_at && j == 5);
        end
        if (pwm_s) high++;
        if (int'(duty_s) != e || busy_s !== 1'b1 || done_s !== 1'b0 ||
            pwm_s !== (j < e)) mis++;
        @(negedge clk);
      end
      check($sformatf("%s_p%0d_wave_errs", tag, k), mis, 0);
      check($sformatf("%s_p%0d_high", tag, k), high, e);
      nper++; hsum += high;
    end
    check({tag, "_done"}, int'(done_s), 1);
    check({tag, "_busy_end"}, int'(busy_s), 0);
    check({tag, "_duty_end"}, int'(duty_s) + int'(pwm_s), 0);
    extra = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      extra += int'(done_s) + int'(busy_s) + int'(pwm_s);
    end
    check({tag, "_idle_after"}, extra, 0);
  endtask

  typedef struct {
    int sd;
    int hl;
    int mx;
    int restart_at;
    int exp_periods;
    int exp_high;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int np, hs, sd, hl, mx, sa, acc;

    vecs[0] = '{sd: 0, hl: 0, mx: 3,  restart_at: 2,  exp_periods: 9,  exp_high: 15};
    vecs[1] = '{sd: 2, hl: 0, mx: 2,  restart_at: -1, exp_periods: 15, exp_high: 16};
    vecs[2] = '{sd: 0, hl: 0, mx: 0,  restart_at: -1, exp_periods: 3,  exp_high: 0};
    vecs[3] = '{sd: 1, hl: 2, mx: 1,  restart_at: -1, exp_periods: 9,  exp_high: 6};
    vecs[4] = '{sd: 0, hl: 0, mx: 15, restart_at: -1, exp_periods: 33, exp_high: 255};

    // Reset state, with start asserted alongside reset.
    repeat (2) @(negedge clk);
    check("rst_pwm", int'(pwm0) + int'(pwm1), 0);
    check("rst_duty", int'(duty0) + int'(duty1), 0);
    check("rst_busy", int'(busy0) + int'(busy1), 0);
    check("rst_done", int'(done0) + int'(done1), 0);
    start1 = 1'b1; start0 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start0 = 1'b0; rst = 1'b0;
    acc = 0;
    repeat (20) begin
      @(negedge clk);
      acc += int'(busy1) + int'(busy0) + int'(done1) + int'(duty1);
    end
    check("start_with_rst_idle", acc, 0);

    // Directed vectors on the single-cycle instance.
    for (int v = 0; v < 5; v++) begin
      run_seq($sformatf("vec%0d", v), 1, vecs[v].sd, vecs[v].hl, vecs[v].mx, -1,
              vecs[v].restart_at, np, hs);
      check($sformatf("vec%0d_periods", v), np, vecs[v].exp_periods);
      check($sformatf("vec%0d_high_total", v), hs, vecs[v].exp_high);
    end

    // Free-running instance, stop during the second UP (period 9).
    run_seq("stop2nd", 0, 0, 0, 2, 9, -1, np, hs);
    check("stop2nd_periods", np, 15);

    // Reset in the middle of HOLD_HI, then a clean restart.
    @(negedge clk);
    sel = 1'b1; step_div = 16'd0; hold_len = 8'd3; max_duty = PB'(2);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (PER * 4 + 5) @(negedge clk);
    check("hh_duty_before_rst", int'(duty1), 2);
    check("hh_busy_before_rst", int'(busy1), 1);
    rst = 1'b1;
    #1;
    check("hh_rst_outputs", int'(pwm1) + int'(duty1) + int'(busy1) + int'(done1), 0);
    @(negedge clk);
    rst = 1'b0;
    acc = 0;
    repeat (40) begin
      @(negedge clk);
      acc += int'(done1) + int'(busy1);
    end
    check("hh_no_done_after_rst", acc, 0);
    run_seq("restart", 1, 0, 0, 3, -1, -1, np, hs);
    check("restart_periods", np, 9);

    // Randomised configurations on both instances.
    for (int r = 0; r < 12; r++) begin
      sd = int'($urandom_range(0, 2));
      hl = int'($urandom_range(0, 2));
      mx = int'($urandom_range(0, 15));
      if (r % 2 == 0) begin
        sa = int'($urandom_range(0, 40));
        run_seq($sformatf("rnd%0d", r), 0, sd, hl, mx, sa, -1, np, hs);
      end else begin
        sa = ($urandom_range(0, 1) != 0) ? -1 : int'($urandom_range(0, 20));
        run_seq($sformatf("rnd%0d", r), 1, sd, hl, mx, sa, int'($urandom_range(0, 3)), np, hs);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
